// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU operand loader:
//               phase encoding, word geometry and default debounce length.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Loader phase encoding; the numeric values are visible on the phase port.
    typedef enum logic [1:0] {
        PH_LOAD_A = 2'd0,
        PH_LOAD_B = 2'd1,
        PH_DONE   = 2'd2,
        PH_RSVD   = 2'd3
    } phase_e;

    localparam int BYTES_PER_WORD          = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Byte index of the most significant byte of an operand word.
    localparam logic [1:0] C_BYTE_IDX_MSB = 2'(BYTES_PER_WORD - 1);

endpackage
`default_nettype wire

// File: rtl/alu_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_loader_if
// Description : Button/switch inputs and operand outputs of the loader.
//               master = board side driving buttons and switches,
//               slave  = the loader itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_loader_if;
    import alu_pkg::*;

    logic                          load_btn;
    logic                          clr_btn;
    logic [7:0]                    data_sw;
    logic [8*BYTES_PER_WORD-1:0]   A;
    logic [8*BYTES_PER_WORD-1:0]   B;
    logic                          operands_valid;
    logic [1:0]                    phase;
    logic [1:0]                    byte_idx;

    modport master (
        output load_btn,
        output clr_btn,
        output data_sw,
        input  A,
        input  B,
        input  operands_valid,
        input  phase,
        input  byte_idx
    );

    modport slave (
        input  load_btn,
        input  clr_btn,
        input  data_sw,
        output A,
        output B,
        output operands_valid,
        output phase,
        output byte_idx
    );

endinterface
`default_nettype wire

// File: rtl/alu_operand_loader_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : 2-flop synchronizer, stability counter and one-cycle pulse
//               on each accepted 0->1 change of the debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn,
    output logic      o_pulse
);

    // DEBOUNCE_CYCLES is at least 2, so the width is at least 1.
    localparam int            CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_pulse;
    logic          w_sync;

    assign w_sync  = r_sync[1];
    assign o_pulse = r_pulse;

    // Synchronize the raw button, then accept a new level only after it has
    // differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= 1'b0;
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_level <= w_sync;
                r_cnt   <= '0;
                // Only a rising debounced level produces a pulse.
                r_pulse <= w_sync;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_loader
// Description : Builds 32-bit ALU operands A and B from byte-wide switch
//               entries, one debounced button press per byte, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_operand_loader_if.slave bus
);

    logic        w_load_pulse;
    logic [1:0]  r_clr_sync;
    logic        w_clr;

    phase_e      r_phase;
    phase_e      w_phase_nxt;
    logic [1:0]  r_byte_idx;
    logic [1:0]  w_byte_idx_nxt;
    logic [31:0] r_a;
    logic [31:0] w_a_nxt;
    logic [31:0] r_b;
    logic [31:0] w_b_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [4:0]  w_bit_base;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.load_btn),
        .o_pulse (w_load_pulse)
    );

    // Clear acts on its synchronized level; no debounce is needed because
    // repeated clears are harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_sync <= 2'b00;
        end else begin
            r_clr_sync <= {r_clr_sync[0], bus.clr_btn};
        end
    end

    assign w_clr      = r_clr_sync[1];
    assign w_bit_base = {r_byte_idx, 3'b000};

    // Operand / phase state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase    <= PH_LOAD_A;
            r_byte_idx <= C_BYTE_IDX_MSB;
            r_a        <= '0;
            r_b        <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    // Next-state: clear wins over a coincident load pulse, which is dropped.
    always_comb begin
        w_phase_nxt    = r_phase;
        w_byte_idx_nxt = r_byte_idx;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        if (w_clr) begin
            w_phase_nxt    = PH_LOAD_A;
            w_byte_idx_nxt = C_BYTE_IDX_MSB;
            w_a_nxt        = '0;
            w_b_nxt        = '0;
        end else if (w_load_pulse) begin
            case (r_phase)
                PH_LOAD_A: begin
                    w_a_nxt[w_bit_base +: 8] = bus.data_sw;
                    if (r_byte_idx == 2'd0) begin
                        w_phase_nxt    = PH_LOAD_B;
                        w_byte_idx_nxt = C_BYTE_IDX_MSB;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx - 2'd1;
                    end
                end
                PH_LOAD_B: begin
                    w_b_nxt[w_bit_base +: 8] = bus.data_sw;
                    if (r_byte_idx == 2'd0) begin
                        w_phase_nxt    = PH_DONE;
                        w_byte_idx_nxt = 2'd0;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx - 2'd1;
                    end
                end
                PH_DONE: begin
                    // A press after a complete pair starts a fresh set with
                    // this byte as the new A MSB.
                    w_a_nxt        = {bus.data_sw, 24'h000000};
                    w_b_nxt        = '0;
                    w_phase_nxt    = PH_LOAD_A;
                    w_byte_idx_nxt = C_BYTE_IDX_MSB - 2'd1;
                end
                default: begin
                    // Unused encoding: recover to the start of a load.
                    w_phase_nxt    = PH_LOAD_A;
                    w_byte_idx_nxt = C_BYTE_IDX_MSB;
                end
            endcase
        end
        w_valid_nxt = (w_phase_nxt == PH_DONE);
    end

    assign bus.A              = r_a;
    assign bus.B              = r_b;
    assign bus.phase          = r_phase;
    assign bus.byte_idx       = r_byte_idx;
    assign bus.operands_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_loader
// Description : Scoreboard bench for alu_operand_loader with DEBOUNCE_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ph;
        logic [1:0]  idx;
        logic        v;
        int          cyc;
        string       name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   req_cnt  = 0;
    int   ack_cnt  = 0;
    bit   done     = 1'b0;
    exp_t q[$];

    alu_operand_loader_if bus ();

    alu_operand_loader #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] ph, input logic [1:0] idx,
                                input logic v, input int c, input string nm);
        exp_t e;
        e.a = a; e.b = b; e.ph = ph; e.idx = idx; e.v = v; e.cyc = c; e.name = nm;
        q.push_back(e);
    endtask

    // Immediate state check, serviced by the monitor on the next negedge.
    task automatic sample(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] ph, input logic [1:0] idx,
                          input logic v, input string nm);
        expect_state(a, b, ph, idx, v, -1, nm);
        req_cnt++;
        tick(2);
    endtask

    // Clean press: expected write lands 7 edges after the raw rise.
    task automatic press(input logic [7:0] d, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ph, input logic [1:0] idx, input logic v,
                         input int hold, input string nm);
        bus.data_sw  = d;
        bus.load_btn = 1'b1;
        expect_state(a, b, ph, idx, v, cyc + 7, nm);
        tick(hold);
        bus.load_btn = 1'b0;
        tick(10);
    endtask

    task automatic compare(input exp_t e);
        checks++;
        if (bus.A !== e.a || bus.B !== e.b || bus.phase !== e.ph ||
            bus.byte_idx !== e.idx || bus.operands_valid !== e.v) begin
            failures++;
            $display("FAIL %s: got A=%h B=%h phase=%0d idx=%0d valid=%b, want A=%h B=%h phase=%0d idx=%0d valid=%b",
                     e.name, bus.A, bus.B, bus.phase, bus.byte_idx, bus.operands_valid,
                     e.a, e.b, e.ph, e.idx, e.v);
        end
        if (e.cyc >= 0) begin
            checks++;
            if (cyc != e.cyc) begin
                failures++;
                $display("FAIL %s_latency: changed at cycle %0d, want cycle %0d", e.name, cyc, e.cyc);
            end
        end
    endtask

    // Monitor: compares on every requested sample and on every output change.
    initial begin : mon
        logic [68:0] prev;
        logic [68:0] snap;
        bit          started;
        started = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            snap = {bus.A, bus.B, bus.phase, bus.byte_idx, bus.operands_valid};
            if (req_cnt != ack_cnt) begin
                ack_cnt++;
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sample_queue: got empty queue, want an expected entry");
                end else begin
                    compare(q.pop_front());
                end
                prev    = snap;
                started = 1'b1;
            end else if (started && snap != prev) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_change: got A=%h B=%h phase=%0d idx=%0d valid=%b at cycle %0d, want no change",
                             bus.A, bus.B, bus.phase, bus.byte_idx, bus.operands_valid, cyc);
                end else begin
                    compare(q.pop_front());
                end
                prev = snap;
            end
            if (done) begin
                checks++;
                if (q.size() != 0) begin
                    failures++;
                    $display("FAIL pending_expect: got %0d unseen changes (first %s), want 0", q.size(), q[0].name);
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin
        bus.load_btn = 1'b0;
        bus.clr_btn  = 1'b0;
        bus.data_sw  = 8'h00;
        rst_n        = 1'b0;
        tick(2);
        rst_n = 1'b1;
        sample(32'h0, 32'h0, 2'd0, 2'd3, 1'b0, "reset_state");

        press(8'h12, 32'h12000000, 32'h0, 2'd0, 2'd2, 1'b0, 8, "load_a3");
        press(8'h34, 32'h12340000, 32'h0, 2'd0, 2'd1, 1'b0, 8, "load_a2");
        press(8'h56, 32'h12345600, 32'h0, 2'd0, 2'd0, 1'b0, 8, "load_a1");
        press(8'h78, 32'h12345678, 32'h0, 2'd1, 2'd3, 1'b0, 8, "load_a0");
        press(8'h33, 32'h12345678, 32'h33000000, 2'd1, 2'd2, 1'b0, 8, "load_b3");
        press(8'h33, 32'h12345678, 32'h33330000, 2'd1, 2'd1, 1'b0, 8, "load_b2");
        press(8'h22, 32'h12345678, 32'h33332200, 2'd1, 2'd0, 1'b0, 8, "load_b1");
        press(8'h22, 32'h12345678, 32'h33332222, 2'd2, 2'd0, 1'b1, 8, "load_b0_done");

        // Three-cycle glitch must be ignored.
        bus.data_sw  = 8'hFF;
        bus.load_btn = 1'b1;
        tick(3);
        bus.load_btn = 1'b0;
        tick(12);
        sample(32'h12345678, 32'h33332222, 2'd2, 2'd0, 1'b1, "glitch_ignored");

        // Long hold from DONE: one write, fresh operand set, no release write.
        press(8'hAB, 32'hAB000000, 32'h0, 2'd0, 2'd2, 1'b0, 50, "done_restart_held");
        sample(32'hAB000000, 32'h0, 2'd0, 2'd2, 1'b0, "held_release_no_write");

        // Clear level alone: two sync flops then applied.
        bus.clr_btn = 1'b1;
        expect_state(32'h0, 32'h0, 2'd0, 2'd3, 1'b0, cyc + 3, "clear_level");
        tick(1);
        bus.clr_btn = 1'b0;
        tick(6);

        press(8'h12, 32'h12000000, 32'h0, 2'd0, 2'd2, 1'b0, 8, "midload_a3");
        press(8'h34, 32'h12340000, 32'h0, 2'd0, 2'd1, 1'b0, 8, "midload_a2");

        // Clear arriving on the same edge as the load pulse wins.
        bus.data_sw  = 8'h56;
        bus.load_btn = 1'b1;
        expect_state(32'h0, 32'h0, 2'd0, 2'd3, 1'b0, cyc + 7, "clear_over_pulse");
        tick(4);
        bus.clr_btn = 1'b1;
        tick(1);
        bus.clr_btn = 1'b0;
        tick(4);
        bus.load_btn = 1'b0;
        tick(10);
        sample(32'h0, 32'h0, 2'd0, 2'd3, 1'b0, "clear_over_pulse_hold");

        press(8'h12, 32'h12000000, 32'h0, 2'd0, 2'd2, 1'b0, 8, "reload_a3");
        press(8'h34, 32'h12340000, 32'h0, 2'd0, 2'd1, 1'b0, 8, "reload_a2");

        // Reset mid-load discards the partial operand.
        rst_n = 1'b0;
        expect_state(32'h0, 32'h0, 2'd0, 2'd3, 1'b0, cyc + 1, "reset_midload");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        sample(32'h0, 32'h0, 2'd0, 2'd3, 1'b0, "reset_midload_state");

        press(8'h9A, 32'h9A000000, 32'h0, 2'd0, 2'd2, 1'b0, 8, "post_reset_press");

        tick(5);
        done = 1'b1;
        tick(20);
        $display("FAIL monitor_stall: got no summary, want summary");
        $fatal(1, "monitor did not finish");
    end

endmodule
`default_nettype wire
